// File: rtl/mmap_m_axi_pkg.sv
// Shared constants, helper functions and splitter state type for the m_axi read engine.
package mmap_m_axi_pkg;

  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [0:0] {IDLE, ISSUE} split_state_e;

  function automatic int unsigned log2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
    return r;
  endfunction

  function automatic int unsigned bus_bytes_f(input int unsigned bus_w);
    return bus_w / 8;
  endfunction

  function automatic int unsigned ratio_f(input int unsigned bus_w, input int unsigned user_w);
    return bus_w / user_w;
  endfunction

endpackage

// File: rtl/mmap_m_axi_fifo.sv
// Small show-ahead FIFO used for per-request bookkeeping in the m_axi engines.
module mmap_m_axi_fifo
  import mmap_m_axi_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = (DEPTH > 1) ? log2_f(DEPTH) : 1;
  localparam int unsigned CW = log2_f(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_push = en_i && push_i && !full_o;
  assign do_pop  = en_i && pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mmap_m_axi_r_downsizer.sv
// Splits each bus beat into user words LSB first and flags the last word of each request.
module mmap_m_axi_r_downsizer
  import mmap_m_axi_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH  = 512,
  parameter int unsigned USER_DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_data_i,
  input  logic                       bus_valid_i,
  output logic                       bus_ready_o,
  input  logic [31:0]                req_len_i,
  input  logic                       req_avail_i,
  output logic                       req_pop_o,
  output logic [USER_DATA_WIDTH-1:0] word_o,
  output logic                       word_last_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i
);
  localparam int unsigned RATIO = ratio_f(BUS_DATA_WIDTH, USER_DATA_WIDTH);
  localparam int unsigned LW    = (RATIO > 1) ? log2_f(RATIO) : 1;

  logic [BUS_DATA_WIDTH-1:0] beat_q;
  logic                      full_q, full_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      last_word, last_lane, word_hs, beat_hs;

  assign word_valid_o = full_q && req_avail_i;
  assign word_o       = beat_q[lane_q*USER_DATA_WIDTH +: USER_DATA_WIDTH];
  assign last_word    = (cnt_q == req_len_i - 32'd1);
  assign last_lane    = last_word || (lane_q == LW'(RATIO - 1));
  assign word_last_o  = last_word;
  assign word_hs      = en_i && word_valid_o && word_ready_i;
  // Refill in the same cycle the final lane leaves, so beats stream without a bubble.
  assign bus_ready_o  = en_i && (!full_q || (last_lane && word_ready_i && req_avail_i));
  assign beat_hs      = bus_valid_i && bus_ready_o;
  assign req_pop_o    = word_hs && last_word;

  always_comb begin
    full_d = full_q;
    lane_d = lane_q;
    cnt_d  = cnt_q;
    if (beat_hs) begin
      full_d = 1'b1;
      lane_d = '0;
    end else if (word_hs && last_lane) begin
      full_d = 1'b0;
    end else if (word_hs) begin
      lane_d = lane_q + 1'b1;
    end
    if (word_hs) cnt_d = last_word ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      lane_q <= '0;
      cnt_q  <= '0;
    end else if (en_i) begin
      full_q <= full_d;
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_hs) beat_q <= bus_data_i;
  end

endmodule

// File: rtl/mmap_m_axi_read_dw.sv
// Read master: splits word requests into 4 KB-safe INCR bursts under an outstanding
// burst limit and downsizes the returning beats into user words.
module mmap_m_axi_read_dw
  import mmap_m_axi_pkg::*;
#(
  parameter int unsigned C_M_AXI_ID_WIDTH      = 1,
  parameter int unsigned BUS_ADDR_WIDTH        = 64,
  parameter int unsigned BUS_DATA_WIDTH        = 512,
  parameter int unsigned USER_DATA_WIDTH       = 32,
  parameter int unsigned NUM_READ_OUTSTANDING  = 4,
  parameter int unsigned MAX_READ_BURST_LENGTH = 16,
  parameter logic [3:0]  C_CACHE_VALUE         = 4'b0011,
  parameter logic [2:0]  C_PROT_VALUE          = 3'b000
) (
  input  logic                        ACLK,
  input  logic                        ARESET_N,
  input  logic                        ACLK_EN,
  output logic [C_M_AXI_ID_WIDTH-1:0] out_BUS_ARID,
  output logic [BUS_ADDR_WIDTH-1:0]   out_BUS_ARADDR,
  output logic [7:0]                  out_BUS_ARLEN,
  output logic [2:0]                  out_BUS_ARSIZE,
  output logic [1:0]                  out_BUS_ARBURST,
  output logic [3:0]                  out_BUS_ARCACHE,
  output logic [2:0]                  out_BUS_ARPROT,
  output logic                        out_BUS_ARVALID,
  input  logic                        in_BUS_ARREADY,
  input  logic [BUS_DATA_WIDTH-1:0]   in_BUS_RDATA,
  input  logic [1:0]                  in_BUS_RRESP,
  input  logic                        in_BUS_RLAST,
  input  logic                        in_BUS_RVALID,
  output logic                        out_BUS_RREADY,
  input  logic [BUS_ADDR_WIDTH-1:0]   in_HLS_ARADDR,
  input  logic [31:0]                 in_HLS_ARLEN,
  input  logic                        in_HLS_ARVALID,
  output logic                        out_HLS_ARREADY,
  output logic [USER_DATA_WIDTH-1:0]  out_HLS_RDATA,
  output logic                        out_HLS_RLAST,
  output logic                        out_HLS_RVALID,
  input  logic                        in_HLS_RREADY,
  output logic                        out_ERR
);
  localparam int unsigned BUS_BYTES = bus_bytes_f(BUS_DATA_WIDTH);
  localparam int unsigned RATIO     = ratio_f(BUS_DATA_WIDTH, USER_DATA_WIDTH);
  localparam int unsigned BSH       = log2_f(BUS_BYTES);
  localparam int unsigned RSH       = log2_f(RATIO);
  localparam int unsigned OW        = log2_f(NUM_READ_OUTSTANDING + 1);

  split_state_e              state_q, state_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [32:0]               rem_q, rem_d, burst;
  logic [7:0]                arlen_q, arlen_d;
  logic                      arvalid_q, arvalid_d, err_q, err_d;
  logic [OW-1:0]             outst_q, outst_d;
  logic [12:0]               page_beats;
  logic [8:0]                nbeats;
  logic                      info_push, info_pop, info_empty, info_full;
  logic [31:0]               info_len;
  logic                      hls_ar_hs, ar_hs, r_hs;

  assign out_HLS_ARREADY = ARESET_N && ACLK_EN && (state_q == IDLE) && !info_full;
  assign hls_ar_hs       = in_HLS_ARVALID && out_HLS_ARREADY;
  assign ar_hs           = ACLK_EN && arvalid_q && in_BUS_ARREADY;
  assign r_hs            = in_BUS_RVALID && out_BUS_RREADY;
  assign page_beats      = 13'((PAGE_BYTES - 32'(addr_q[11:0])) >> BSH);
  assign nbeats          = {1'b0, arlen_q} + 9'd1;

  always_comb begin
    burst = rem_q;
    if (burst > 33'(MAX_READ_BURST_LENGTH)) burst = 33'(MAX_READ_BURST_LENGTH);
    if (burst > 33'(page_beats))            burst = 33'(page_beats);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    info_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (hls_ar_hs && in_HLS_ARLEN != 32'd0) begin
          addr_d    = in_HLS_ARADDR;
          rem_d     = (33'(in_HLS_ARLEN) + 33'(RATIO - 1)) >> RSH;
          info_push = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // ARADDR/ARLEN come straight from addr_q/arlen_q, so they stay put until accepted.
        if (arvalid_q) begin
          if (ar_hs) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + (BUS_ADDR_WIDTH'(nbeats) << BSH);
            rem_d     = rem_q - 33'(nbeats);
            if (rem_d == '0) state_d = IDLE;
          end
        end else if (32'(outst_q) < NUM_READ_OUTSTANDING) begin
          arvalid_d = 1'b1;
          arlen_d   = 8'(burst - 33'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (ar_hs && !(r_hs && in_BUS_RLAST))      outst_d = outst_q + 1'b1;
    else if (!ar_hs && r_hs && in_BUS_RLAST)   outst_d = outst_q - 1'b1;
  end

  assign err_d = err_q | (r_hs && in_BUS_RRESP != 2'b00);

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      arvalid_q <= 1'b0;
      outst_q   <= '0;
      err_q     <= 1'b0;
    end else if (ACLK_EN) begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      arvalid_q <= arvalid_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ACLK_EN) begin
      addr_q  <= addr_d;
      arlen_q <= arlen_d;
    end
  end

  assign out_BUS_ARID    = '0;
  assign out_BUS_ARADDR  = addr_q;
  assign out_BUS_ARLEN   = arlen_q;
  assign out_BUS_ARSIZE  = 3'(BSH);
  assign out_BUS_ARBURST = 2'b01;
  assign out_BUS_ARCACHE = C_CACHE_VALUE;
  assign out_BUS_ARPROT  = C_PROT_VALUE;
  assign out_BUS_ARVALID = arvalid_q;
  assign out_ERR         = err_q;

  mmap_m_axi_fifo #(
    .WIDTH (32),
    .DEPTH (NUM_READ_OUTSTANDING)
  ) u_info_fifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESET_N),
    .en_i    (ACLK_EN),
    .push_i  (info_push),
    .data_i  (in_HLS_ARLEN),
    .pop_i   (info_pop),
    .data_o  (info_len),
    .empty_o (info_empty),
    .full_o  (info_full)
  );

  mmap_m_axi_r_downsizer #(
    .BUS_DATA_WIDTH  (BUS_DATA_WIDTH),
    .USER_DATA_WIDTH (USER_DATA_WIDTH)
  ) u_downsizer (
    .clk_i        (ACLK),
    .rst_ni       (ARESET_N),
    .en_i         (ACLK_EN),
    .bus_data_i   (in_BUS_RDATA),
    .bus_valid_i  (in_BUS_RVALID),
    .bus_ready_o  (out_BUS_RREADY),
    .req_len_i    (info_len),
    .req_avail_i  (!info_empty),
    .req_pop_o    (info_pop),
    .word_o       (out_HLS_RDATA),
    .word_last_o  (out_HLS_RLAST),
    .word_valid_o (out_HLS_RVALID),
    .word_ready_i (in_HLS_RREADY)
  );

endmodule

// File: tb/tb_mmap_m_axi_read_dw.sv
// Scoreboard bench for mmap_m_axi_read_dw: a bus slave model returns beats whose
// 32-bit lanes carry their own byte address, so every HLS word is self-describing.
module tb_mmap_m_axi_read_dw;

  typedef struct packed { logic [31:0] data; logic last; } word_t;
  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;

  logic         clk = 1'b0;
  logic         rst_n, en;
  logic [0:0]   bus_arid;
  logic [63:0]  bus_araddr;
  logic [7:0]   bus_arlen;
  logic [2:0]   bus_arsize, bus_arprot;
  logic [1:0]   bus_arburst, bus_rresp;
  logic [3:0]   bus_arcache;
  logic         bus_arvalid, bus_arready;
  logic [511:0] bus_rdata;
  logic         bus_rlast, bus_rvalid, bus_rready;
  logic [63:0]  hls_araddr;
  logic [31:0]  hls_arlen, hls_rdata;
  logic         hls_arvalid, hls_arready, hls_rlast, hls_rvalid, hls_rready;
  logic         err;

  word_t exp_words[$];
  ar_t   exp_ar[$];
  ar_t   bursts[$];
  int    pass_cnt = 0, total_cnt = 0;
  int    ar_count = 0, words_seen = 0, r_budget = 0;
  logic  tog = 1'b0;
  logic [63:0] err_addr = '1;

  always #5 clk = ~clk;

  mmap_m_axi_read_dw dut (
    .ACLK(clk), .ARESET_N(rst_n), .ACLK_EN(en),
    .out_BUS_ARID(bus_arid), .out_BUS_ARADDR(bus_araddr), .out_BUS_ARLEN(bus_arlen),
    .out_BUS_ARSIZE(bus_arsize), .out_BUS_ARBURST(bus_arburst), .out_BUS_ARCACHE(bus_arcache),
    .out_BUS_ARPROT(bus_arprot), .out_BUS_ARVALID(bus_arvalid), .in_BUS_ARREADY(bus_arready),
    .in_BUS_RDATA(bus_rdata), .in_BUS_RRESP(bus_rresp), .in_BUS_RLAST(bus_rlast),
    .in_BUS_RVALID(bus_rvalid), .out_BUS_RREADY(bus_rready),
    .in_HLS_ARADDR(hls_araddr), .in_HLS_ARLEN(hls_arlen), .in_HLS_ARVALID(hls_arvalid),
    .out_HLS_ARREADY(hls_arready), .out_HLS_RDATA(hls_rdata), .out_HLS_RLAST(hls_rlast),
    .out_HLS_RVALID(hls_rvalid), .in_HLS_RREADY(hls_rready), .out_ERR(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [511:0] beat_data(input logic [63:0] baddr);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = baddr[31:0] + 32'(4 * i);
    return d;
  endfunction

  task automatic push_ar(input logic [63:0] a, input logic [7:0] l);
    exp_ar.push_back('{addr: a, len: l});
  endtask

  task automatic send_req(input logic [63:0] a, input logic [31:0] len);
    logic got;
    got = 1'b0;
    hls_araddr = a; hls_arlen = len; hls_arvalid = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      got = hls_arready && en;
    end
    if (!got) fail("req_accept", 64'(hls_arready), 64'd1);
    else for (int k = 0; k < int'(len); k++)
      exp_words.push_back('{data: a[31:0] + 32'(4 * k), last: (k == int'(len) - 1)});
    @(posedge clk); #1;
    hls_arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_words.size() != 0 || exp_ar.size() != 0) && n < 5000) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drain"}, 64'(exp_words.size() + exp_ar.size()), 64'd0);
  endtask

  // AR channel monitor and scoreboard
  initial begin
    ar_t e;
    forever begin
      @(negedge clk);
      if (rst_n && en && bus_arvalid && bus_arready) begin
        ar_count++;
        if (exp_ar.size() == 0) fail("ar_unexpected", bus_araddr, 64'd0);
        else begin
          e = exp_ar.pop_front();
          check("araddr", bus_araddr, e.addr);
          check("arlen", 64'(bus_arlen), 64'(e.len));
        end
        check("ar_fixed", {bus_arid, bus_arsize, bus_arburst, bus_arcache, bus_arprot},
              {1'b0, 3'd6, 2'b01, 4'b0011, 3'b000});
        bursts.push_back('{addr: bus_araddr, len: bus_arlen});
      end
    end
  end

  // R channel slave model
  initial begin
    int beat_idx;
    logic [63:0] baddr;
    beat_idx = 0;
    bus_rvalid = 1'b0; bus_rdata = '0; bus_rlast = 1'b0; bus_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n && en && bus_rvalid && bus_rready) begin
        if (bus_rlast) begin bursts.delete(0); beat_idx = 0; r_budget--; end
        else beat_idx++;
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        bursts.delete(); beat_idx = 0; bus_rvalid = 1'b0;
      end else if (bursts.size() != 0 && r_budget > 0) begin
        baddr      = bursts[0].addr + 64'(beat_idx * 64);
        bus_rdata  = beat_data(baddr);
        bus_rlast  = (beat_idx == int'(bursts[0].len));
        bus_rresp  = (baddr == err_addr) ? 2'b10 : 2'b00;
        bus_rvalid = 1'b1;
      end else begin
        bus_rvalid = 1'b0;
      end
    end
  end

  // HLS R monitor: pops expected words and checks hold-while-stalled
  initial begin
    logic stalled;
    logic [32:0] held;
    word_t w;
    stalled = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 1'b0;
      else begin
        if (stalled) check("hold_stable", {hls_rvalid, hls_rlast, hls_rdata}, {1'b1, held});
        if (en && hls_rvalid && hls_rready) begin
          words_seen++;
          if (exp_words.size() == 0) fail("word_unexpected", 64'(hls_rdata), 64'd0);
          else begin
            w = exp_words.pop_front();
            check("word_data", 64'(hls_rdata), 64'(w.data));
            check("word_last", 64'(hls_rlast), 64'(w.last));
          end
          stalled = 1'b0;
        end else if (hls_rvalid) begin
          stalled = 1'b1;
          held = {hls_rlast, hls_rdata};
        end else stalled = 1'b0;
      end
    end
  end

  initial begin
    hls_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      hls_rready = tog ? ~hls_rready : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    int base, w0;
    logic [43:0] snap;
    rst_n = 1'b0; en = 1'b1; bus_arready = 1'b1;
    hls_arvalid = 1'b0; hls_araddr = '0; hls_arlen = '0;
    r_budget = 1000000;
    repeat (3) @(posedge clk); #1;
    check("rst_arvalid", 64'(bus_arvalid), 64'd0);
    check("rst_hls_arready", 64'(hls_arready), 64'd0);
    check("rst_hls_rvalid", 64'(hls_rvalid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_arready", 64'(hls_arready), 64'd1);

    // single burst, two beats
    push_ar(64'h1000, 8'd1);
    send_req(64'h1000, 32'd32);
    wait_drain("t1");

    // 4 KB boundary split
    push_ar(64'h0FC0, 8'd0);
    push_ar(64'h1000, 8'd2);
    send_req(64'h0FC0, 32'd64);
    wait_drain("t2");

    // partial final beat, then a request that must start at lane 0
    push_ar(64'h3000, 8'd1);
    send_req(64'h3000, 32'd20);
    push_ar(64'h4000, 8'd0);
    send_req(64'h4000, 32'd16);
    wait_drain("t3");

    // zero-length request is consumed silently
    base = ar_count;
    send_req(64'h7000, 32'd0);
    repeat (10) @(posedge clk); #1;
    check("len0_no_ar", 64'(ar_count), 64'(base));
    check("len0_ready", 64'(hls_arready), 64'd1);

    // outstanding limit with read data withheld
    r_budget = 0;
    base = ar_count;
    push_ar(64'h10000, 8'd15);
    push_ar(64'h10400, 8'd15);
    push_ar(64'h10800, 8'd15);
    push_ar(64'h10C00, 8'd15);
    push_ar(64'h20000, 8'd0);
    send_req(64'h10000, 32'd1024);
    send_req(64'h20000, 32'd16);
    repeat (40) @(posedge clk); #1;
    check("limit_ar_count", 64'(ar_count), 64'(base + 4));
    check("limit_arvalid", 64'(bus_arvalid), 64'd0);
    r_budget = 1;
    for (int n = 0; n < 600 && ar_count != base + 5; n++) @(negedge clk);
    check("release_ar_count", 64'(ar_count), 64'(base + 5));
    @(posedge clk); #1;
    r_budget = 1000000;
    wait_drain("t4");

    // ready toggling with a 3-cycle clock-enable freeze in the middle
    tog = 1'b1;
    push_ar(64'h30000, 8'd2);
    send_req(64'h30000, 32'd48);
    repeat (12) @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    snap = {bus_arvalid, hls_rvalid, hls_rlast, hls_rdata, err, bus_arlen};
    check("freeze_rvalid", 64'(hls_rvalid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("freeze_outputs", 64'({bus_arvalid, hls_rvalid, hls_rlast, hls_rdata, err, bus_arlen}),
            64'(snap));
    end
    @(posedge clk); #1;
    en = 1'b1;
    wait_drain("t5_toggle");
    tog = 1'b0;

    // error response is sticky
    err_addr = 64'h40040;
    push_ar(64'h40000, 8'd3);
    send_req(64'h40000, 32'd64);
    wait_drain("t5_err");
    check("err_set", 64'(err), 64'd1);
    push_ar(64'h41000, 8'd0);
    send_req(64'h41000, 32'd16);
    wait_drain("t5_err_hold");
    check("err_sticky", 64'(err), 64'd1);

    // asynchronous reset in the middle of a burst
    push_ar(64'h50000, 8'd15);
    w0 = words_seen;
    send_req(64'h50000, 32'd256);
    for (int n = 0; n < 300 && words_seen < w0 + 20; n++) @(posedge clk);
    check("midburst_progress", 64'(words_seen >= w0 + 20), 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_err", 64'(err), 64'd0);
    check("arst_hls_rvalid", 64'(hls_rvalid), 64'd0);
    check("arst_arvalid", 64'(bus_arvalid), 64'd0);
    check("arst_hls_arready", 64'(hls_arready), 64'd0);
    exp_words.delete();
    exp_ar.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("post_rst_err", 64'(err), 64'd0);
    push_ar(64'h60000, 8'd0);
    send_req(64'h60000, 32'd16);
    wait_drain("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mmap_m_axi_read_dw.md
Name: mmap_m_axi_read_dw

Overview:
Second-generation m_axi read engine for the input loaders. Accepts word-granular read requests from the HLS side and splits them into AXI4 INCR bursts that never cross a 4 KB boundary, bounded by a credit-based outstanding limit. Each wide bus beat is downsized into USER_DATA_WIDTH words, and only the final word of each request is flagged.

Parameters:
C_M_AXI_ID_WIDTH, 1, ARID width (driven 0)
BUS_ADDR_WIDTH, 64, byte address width
BUS_DATA_WIDTH, 512, AXI data width; power of 2, at least USER_DATA_WIDTH
USER_DATA_WIDTH, 32, HLS word width; divides BUS_DATA_WIDTH
NUM_READ_OUTSTANDING, 4, max bursts in flight; also request-info FIFO depth
MAX_READ_BURST_LENGTH, 16, max beats per burst (1..256)
C_CACHE_VALUE, 4'b0011, ARCACHE value
C_PROT_VALUE, 3'b000, ARPROT value

Ports:
ACLK  in  1  clock
ARESET_N  in  1  asynchronous active-low reset
ACLK_EN  in  1  global enable; when 0, all state holds
out_BUS_ARID  out  C_M_AXI_ID_WIDTH  constant 0
out_BUS_ARADDR  out  BUS_ADDR_WIDTH  burst start byte address
out_BUS_ARLEN  out  8  beats-1
out_BUS_ARSIZE  out  3  log2(BUS_DATA_WIDTH/8)
out_BUS_ARBURST  out  2  2'b01
out_BUS_ARCACHE  out  4  C_CACHE_VALUE
out_BUS_ARPROT  out  3  C_PROT_VALUE
out_BUS_ARVALID  out  1  address valid
in_BUS_ARREADY  in  1  address ready
in_BUS_RDATA  in  BUS_DATA_WIDTH  read data
in_BUS_RRESP  in  2  response
in_BUS_RLAST  in  1  last beat of burst
in_BUS_RVALID  in  1  data valid
out_BUS_RREADY  out  1  data ready
in_HLS_ARADDR  in  BUS_ADDR_WIDTH  byte address; must be aligned to BUS_DATA_WIDTH/8
in_HLS_ARLEN  in  32  request length in user words
in_HLS_ARVALID  in  1  request valid
out_HLS_ARREADY  out  1  request ready
out_HLS_RDATA  out  USER_DATA_WIDTH  word
out_HLS_RLAST  out  1  last word of request
out_HLS_RVALID  out  1  word valid
in_HLS_RREADY  in  1  word ready
out_ERR  out  1  sticky: set on any RRESP other than 2'b00

Behaviour:
- Reset (asynchronous, ARESET_N=0): all valids 0, out_HLS_ARREADY 0, out_ERR 0, counters and FIFOs empty, FSM in IDLE.
- RATIO = BUS_DATA_WIDTH/USER_DATA_WIDTH. Beats per request = ceil(ARLEN/RATIO), computed in 33 bits.
- Splitter FSM, IDLE:
  - out_HLS_ARREADY = info FIFO not full.
  - On handshake with ARLEN=0: the request is consumed and nothing is issued or pushed.
  - Otherwise: latch addr and beats, push ARLEN into the info FIFO, go to ISSUE.
- Splitter FSM, ISSUE:
  - Burst beats = min(remaining, MAX_READ_BURST_LENGTH, (4096 - addr[11:0])/BYTES).
  - ARVALID is registered and asserted only when outstanding < NUM_READ_OUTSTANDING.
  - ARADDR and ARLEN are held stable until ARREADY.
  - On handshake: addr += beats*BYTES, remaining -= beats. When remaining reaches 0, go to IDLE, so the next request can be accepted the cycle after.
- Outstanding counter: +1 on AR handshake, -1 on an R handshake with RLAST. Both in the same cycle leaves it unchanged. It never exceeds NUM_READ_OUTSTANDING.
- Downsizer:
  - One beat register plus a lane index. Lanes are emitted LSB first.
  - out_BUS_RREADY = register empty, OR (last lane to be emitted AND in_HLS_RREADY). This gives back-to-back beats with no bubble.
  - Word counter runs against the head of the info FIFO. On the word with count == len-1: RLAST=1, remaining lanes of that beat are discarded, the FIFO pops and the counter clears.
  - A request's final beat always ends in its own register. The next request starts at lane 0.
- HLS R outputs are held stable while RVALID=1 and RREADY=0.
- out_ERR is set on any R handshake with RRESP != 0 and is cleared only by reset.
- Reset mid-operation discards all state. In-flight bus bursts are the system's responsibility.

Decomposition:
- Package mmap_m_axi_pkg holds: the log2 function, BUS_BYTES, RATIO, the 4 KB page constant, and the splitter state enum {IDLE, ISSUE}.
- Reuse the existing m_axi fifo for request-info storage (width 32, depth NUM_READ_OUTSTANDING).
- One sub-module: mmap_m_axi_r_downsizer, containing the beat register, lane index, word counter and RLAST generation.

Test Plan:
All scenarios use defaults (512/32, RATIO 16, BYTES 64).
1. Addr 0x1000, len 32 -> one AR: ARADDR 0x1000, ARLEN 1; 32 words out, RLAST only on word 31.
2. Addr 0x0FC0, len 64 -> two ARs: (0x0FC0, ARLEN 0) then (0x1000, ARLEN 2); RLAST on word 63.
3. Len 20 -> one AR with ARLEN 1; 20 words out; lanes 4..15 of beat 2 dropped; RLAST on word 19; the next request's first word is lane 0.
4. Len 1024 with RVALID withheld -> exactly 4 ARs issued, then ARVALID stays 0. One RLAST beat returns -> the 5th AR is issued.
5. in_HLS_RREADY toggled 1010... -> no word is lost or duplicated and data is stable while stalled; ACLK_EN=0 for 3 cycles freezes all outputs; RRESP=2'b10 on one beat sets out_ERR, which holds until ARESET_N pulses low mid-burst and clears everything asynchronously.
